// File: rtl/bcd_serial_add_ctrl_if.sv
// Operand/result bundle for the serial BCD adder sequencer.
// master drives the operands and start, slave returns the result.
interface bcd_serial_add_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  start;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  cin;
    logic [4*DIGITS-1:0]   sum;
    logic                  cout;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        output start, a, b, cin,
        input  sum, cout, busy, done, err
    );

    modport slave (
        input  start, a, b, cin,
        output sum, cout, busy, done, err
    );
endinterface

// File: rtl/bcd_serial_add_ctrl.sv
// Multi-digit packed-BCD adder that reuses one digit stage,
// stepping least-significant digit first, one digit per clock.
module bcd_serial_add_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    bcd_serial_add_ctrl_if.slave     bus
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            err_q, err_d;
    logic            busy_q;
    logic            done_q;

    logic [3:0]      dig_a;
    logic [3:0]      dig_b;
    logic [4:0]      t;
    logic [4:0]      t_adj;
    logic [3:0]      dig_s;
    logic            dig_c;
    logic            bad_in;

    // Operand digit currently selected by the counter.
    always_comb begin
        dig_a = '0;
        dig_b = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (cnt_q == CW'(i)) begin
                dig_a = a_q[4*i +: 4];
                dig_b = b_q[4*i +: 4];
            end
        end
    end

    // Shared single-digit BCD stage.
    always_comb begin
        t     = {1'b0, dig_a} + {1'b0, dig_b} + {4'b0, carry_q};
        t_adj = t + 5'd6;
        dig_c = (t > 5'd9);
        dig_s = dig_c ? t_adj[3:0] : t[3:0];
    end

    always_comb begin
        bad_in = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.a[4*i +: 4] > 4'd9) bad_in = 1'b1;
            if (bus.b[4*i +: 4] > 4'd9) bad_in = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.cin;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    cnt_d   = '0;
                    err_d   = bad_in;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (cnt_q == CW'(i)) sum_d[4*i +: 4] = dig_s;
                end
                carry_d = dig_c;
                if (cnt_q == LAST) begin
                    cout_d  = dig_c;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_DONE);
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;
endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Randomised and directed bench for the serial BCD adder,
// checked against a decimal-arithmetic reference model.
module tb_bcd_serial_add_ctrl;
    localparam int D = 4;
    localparam int W = 4 * D;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nvec = 0;
    int   nerr = 0;

    bcd_serial_add_ctrl_if #(.DIGITS(D)) bus ();

    bcd_serial_add_ctrl #(.DIGITS(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic bit has_bad(input logic [W-1:0] v);
        for (int i = 0; i < D; i++)
            if (v[4*i +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int bcd2int(input logic [W-1:0] v);
        int r = 0;
        for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int x);
        logic [W-1:0] r = '0;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Decimal arithmetic for legal operands; digit rule otherwise.
    task automatic ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic c, output logic [W-1:0] s,
                           output logic co, output logic e);
        int lim = 1;
        int tot;
        for (int i = 0; i < D; i++) lim = lim * 10;
        e = has_bad(a) || has_bad(b);
        if (!e) begin
            tot = bcd2int(a) + bcd2int(b) + int'(c);
            co  = (tot >= lim);
            s   = int2bcd(tot % lim);
        end else begin
            int cy = int'(c);
            s = '0;
            for (int i = 0; i < D; i++) begin
                int tt = int'(a[4*i +: 4]) + int'(b[4*i +: 4]) + cy;
                if (tt > 9) begin
                    s[4*i +: 4] = 4'((tt + 6) % 16);
                    cy = 1;
                end else begin
                    s[4*i +: 4] = 4'(tt);
                    cy = 0;
                end
            end
            co = cy[0];
        end
    endtask

    function automatic logic [W-1:0] lowmask(input int n);
        logic [W-1:0] m = '0;
        for (int i = 0; i < n; i++) m[4*i +: 4] = 4'hF;
        return m;
    endfunction

    // One full operation with per-cycle checks; optionally pokes
    // a second start mid-operation that must be ignored.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input bit poke);
        logic [W-1:0] es;
        logic eco, ee;
        ref_add(a, b, c, es, eco, ee);
        @(negedge clk);
        bus.start = 1'b1; bus.a = a; bus.b = b; bus.cin = c;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = $urandom; bus.b = $urandom; bus.cin = $urandom;
        nvec++;
        if (bus.sum !== '0 || bus.busy !== 1'b1 || bus.done !== 1'b0 ||
            bus.err !== ee || bus.cout !== 1'b0) begin
            nerr++;
            $display("FAIL accept a=%h b=%h: sum=%h busy=%b done=%b err=%b cout=%b want sum=0 busy=1 done=0 err=%b cout=0",
                     a, b, bus.sum, bus.busy, bus.done, bus.err, bus.cout, ee);
        end
        for (int n = 1; n <= D; n++) begin
            if (poke && n == 2) bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            nvec++;
            if (bus.sum !== (es & lowmask(n)) ||
                bus.done !== (n == D) || bus.busy !== 1'b1 ||
                bus.err !== ee) begin
                nerr++;
                $display("FAIL digit%0d a=%h b=%h: sum=%h done=%b busy=%b err=%b want sum=%h done=%b busy=1 err=%b",
                         n - 1, a, b, bus.sum, bus.done, bus.busy, bus.err,
                         es & lowmask(n), n == D, ee);
            end
        end
        nvec++;
        if (bus.cout !== eco) begin
            nerr++;
            $display("FAIL cout a=%h b=%h cin=%b: got %b want %b",
                     a, b, c, bus.cout, eco);
        end
        @(negedge clk);
        nvec++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.sum !== es ||
            bus.cout !== eco || bus.err !== ee) begin
            nerr++;
            $display("FAIL after_done a=%h b=%h: done=%b busy=%b sum=%h cout=%b err=%b want 0 0 %h %b %b",
                     a, b, bus.done, bus.busy, bus.sum, bus.cout, bus.err,
                     es, eco, ee);
        end
    endtask

    task automatic test_reset();
        nvec++;
        if (bus.sum !== '0 || bus.cout !== 1'b0 || bus.busy !== 1'b0 ||
            bus.done !== 1'b0 || bus.err !== 1'b0) begin
            nerr++;
            $display("FAIL reset: sum=%h cout=%b busy=%b done=%b err=%b want all 0",
                     bus.sum, bus.cout, bus.busy, bus.done, bus.err);
        end
    endtask

    task automatic test_directed();
        run_op(16'h1234, 16'h5678, 1'b0, 1'b0);
        run_op(16'h9999, 16'h0001, 1'b0, 1'b0);
        run_op(16'h9999, 16'h9999, 1'b1, 1'b0);
        run_op(16'h0000, 16'h0000, 1'b1, 1'b0);
    endtask

    task automatic test_invalid();
        run_op(16'h00A5, 16'h0003, 1'b0, 1'b0);
        run_op(16'hF0F0, 16'h0F0F, 1'b1, 1'b0);
    endtask

    task automatic test_ignore_start();
        run_op(16'h4321, 16'h1111, 1'b0, 1'b1);
        for (int i = 0; i < D + 2; i++) begin
            @(negedge clk);
            nvec++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                nerr++;
                $display("FAIL ignore_start cyc%0d: done=%b busy=%b want 0 0",
                         i, bus.done, bus.busy);
            end
        end
    endtask

    task automatic test_midreset();
        @(negedge clk);
        bus.start = 1'b1; bus.a = 16'h8765; bus.b = 16'h1234; bus.cin = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        nvec++;
        if (bus.sum !== '0 || bus.cout !== 1'b0 || bus.busy !== 1'b0 ||
            bus.done !== 1'b0 || bus.err !== 1'b0) begin
            nerr++;
            $display("FAIL midreset: sum=%h cout=%b busy=%b done=%b err=%b want all 0",
                     bus.sum, bus.cout, bus.busy, bus.done, bus.err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < D + 1; i++) begin
            @(negedge clk);
            nvec++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                nerr++;
                $display("FAIL midreset_idle cyc%0d: done=%b busy=%b want 0 0",
                         i, bus.done, bus.busy);
            end
        end
        run_op(16'h0005, 16'h0005, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 30; k++) begin
            logic [W-1:0] a, b;
            a = int2bcd($urandom_range(0, 9999));
            b = int2bcd($urandom_range(0, 9999));
            if (k % 5 == 4) a[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
            run_op(a, b, 1'($urandom), 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] es;
        logic eco, ee;
        int   hits[$];
        ref_add(16'h2468, 16'h1357, 1'b1, es, eco, ee);
        @(negedge clk);
        bus.start = 1'b1; bus.a = 16'h2468; bus.b = 16'h1357; bus.cin = 1'b1;
        for (int c = 1; c <= 3 * (D + 2) + 1; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                hits.push_back(c);
                nvec++;
                if (bus.sum !== es || bus.cout !== eco) begin
                    nerr++;
                    $display("FAIL b2b_result c=%0d: sum=%h cout=%b want %h %b",
                             c, bus.sum, bus.cout, es, eco);
                end
            end
        end
        bus.start = 1'b0;
        nvec++;
        if (hits.size() != 3 || hits[0] != D + 1 ||
            hits[1] - hits[0] != D + 2 || hits[2] - hits[1] != D + 2) begin
            nerr++;
            $display("FAIL b2b_timing: %0d pulses first=%0d want 3 pulses first=%0d spacing %0d",
                     hits.size(), hits.size() > 0 ? hits[0] : -1, D + 1, D + 2);
        end
        for (int i = 0; i < 2 * (D + 2) && bus.busy === 1'b1; i++) @(negedge clk);
        @(negedge clk);
        nvec++;
        if (bus.busy !== 1'b0) begin
            nerr++;
            $display("FAIL b2b_drain: busy=%b want 0", bus.busy);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_directed();
        test_invalid();
        test_ignore_start();
        test_midreset();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
